// File: rtl/reg_file_param_if.sv
// reg_file_param_if: IF/EXE/WB bundle between the PikaRISC pipeline and its register file.
interface reg_file_param_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 4
);
    logic              if_pc_we;
    logic [DATA_W-1:0] if_pc_in;
    logic [DATA_W-1:0] if_pc_out;
    logic [AW-1:0]     exe_rd_num;
    logic [DATA_W-1:0] exe_rd_data_out;
    logic [AW-1:0]     exe_rs_num;
    logic [DATA_W-1:0] exe_rs_data_out;
    logic [AW-1:0]     exe_rt_num;
    logic [DATA_W-1:0] exe_rt_data_out;
    logic [DATA_W-1:0] exe_cpsr_out;
    logic              exe_lock_en;
    logic [AW-1:0]     exe_lock_num;
    logic              exe_rd_busy;
    logic              exe_rs_busy;
    logic              exe_rt_busy;
    logic [AW-1:0]     wb_rd_num;
    logic              wb_rd_write_en;
    logic [DATA_W-1:0] wb_rd_in;
    logic              wb_pc_write_en;
    logic [DATA_W-1:0] wb_pc_in;
    logic              wb_cpsr_write_en;
    logic [DATA_W-1:0] wb_cpsr_in;

    modport master (
        output if_pc_we, if_pc_in, exe_rd_num, exe_rs_num, exe_rt_num, exe_lock_en, exe_lock_num,
               wb_rd_num, wb_rd_write_en, wb_rd_in, wb_pc_write_en, wb_pc_in, wb_cpsr_write_en, wb_cpsr_in,
        input  if_pc_out, exe_rd_data_out, exe_rs_data_out, exe_rt_data_out, exe_cpsr_out,
               exe_rd_busy, exe_rs_busy, exe_rt_busy
    );

    modport slave (
        input  if_pc_we, if_pc_in, exe_rd_num, exe_rs_num, exe_rt_num, exe_lock_en, exe_lock_num,
               wb_rd_num, wb_rd_write_en, wb_rd_in, wb_pc_write_en, wb_pc_in, wb_cpsr_write_en, wb_cpsr_in,
        output if_pc_out, exe_rd_data_out, exe_rs_data_out, exe_rt_data_out, exe_cpsr_out,
               exe_rd_busy, exe_rs_busy, exe_rt_busy
    );
endinterface

// File: rtl/reg_file_param.sv
// reg_file_param: PikaRISC GPR/PC/CPSR register file with per-register busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle WB->EXE/IF forwarding.
module reg_file_param #(
    parameter int                DATA_W     = 32,
    parameter int                NREG       = 16,
    parameter int                AW         = 4,
    parameter logic [DATA_W-1:0] PC_RESET   = '0,
    parameter logic [DATA_W-1:0] CPSR_WMASK = '1
) (
    input logic          clk,
    input logic          reset,
    reg_file_param_if.slave bus
);
    logic [DATA_W-1:0] gpr [NREG];
    logic [DATA_W-1:0] pc, cpsr, cpsr_nxt, wr_data;
    logic [NREG-1:0]   busy, busy_nxt;
    logic [AW-1:0]     wr_num, lock_num;
    logic              wr_en, lock_en, byp;

    assign wr_en    = bus.wb_rd_write_en;
    assign wr_num   = bus.wb_rd_num;
    assign wr_data  = bus.wb_rd_in;
    assign lock_en  = bus.exe_lock_en;
    assign lock_num = bus.exe_lock_num;

    // Forwarding is suppressed while reset is held so outputs show the reset state.
`ifdef REGFILE_BYPASS_EN
    assign byp = reset;
`else
    assign byp = 1'b0;
`endif

    function automatic logic ok(input logic [AW-1:0] n);
        return {1'b0, n} < (AW+1)'(NREG);
    endfunction

    function automatic logic hit(input logic [AW-1:0] n);
        return byp && wr_en && ok(n) && n == wr_num;
    endfunction

    function automatic logic [DATA_W-1:0] rd(input logic [AW-1:0] n);
        return hit(n) ? wr_data : ok(n) ? gpr[n] : '0;
    endfunction

    function automatic logic bz(input logic [AW-1:0] n);
        return hit(n) ? (lock_en && lock_num == n) : (ok(n) && busy[n]);
    endfunction

    always_comb begin
        cpsr_nxt = (cpsr & ~CPSR_WMASK) | (bus.wb_cpsr_in & CPSR_WMASK);
        // A new lock outranks a writeback clearing the same register.
        for (int i = 0; i < NREG; i++)
            busy_nxt[i] = (lock_en && lock_num == AW'(i)) || (busy[i] && !(wr_en && wr_num == AW'(i)));
        bus.if_pc_out       = byp && bus.wb_pc_write_en ? bus.wb_pc_in : pc;
        bus.exe_cpsr_out    = byp && bus.wb_cpsr_write_en ? cpsr_nxt : cpsr;
        bus.exe_rd_data_out = rd(bus.exe_rd_num);
        bus.exe_rs_data_out = rd(bus.exe_rs_num);
        bus.exe_rt_data_out = rd(bus.exe_rt_num);
        bus.exe_rd_busy     = bz(bus.exe_rd_num);
        bus.exe_rs_busy     = bz(bus.exe_rs_num);
        bus.exe_rt_busy     = bz(bus.exe_rt_num);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) gpr[i] <= '0;
            pc   <= PC_RESET;
            cpsr <= '0;
            busy <= '0;
        end else begin
            if (wr_en && ok(wr_num)) gpr[wr_num] <= wr_data;
            if (bus.wb_pc_write_en) pc <= bus.wb_pc_in;
            else if (bus.if_pc_we) pc <= bus.if_pc_in;
            if (bus.wb_cpsr_write_en) cpsr <= cpsr_nxt;
            busy <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed vector table, randomized run against a behavioural model, async reset sequences.
module tb_reg_file_param;
    localparam int NREG = 12;
    localparam logic [31:0] PCR  = 32'h0000_0100;
    localparam logic [31:0] MASK = 32'hF000_0000;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    reg_file_param_if #(.DATA_W(32), .AW(4)) bus();
    reg_file_param #(.DATA_W(32), .NREG(NREG), .AW(4), .PC_RESET(PCR), .CPSR_WMASK(MASK))
        dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] m_gpr [16];
    logic        m_busy [16];
    logic [31:0] m_pc, m_cpsr;

    typedef struct {
        logic [31:0] pcwe, pcin, wpce, wpc, wr, wn, wd, cw, cd, lk, ln, rs;
        logic [31:0] e_rs, e_rsb, e_pc, e_cpsr;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d);
        return (old & ~MASK) | (d & MASK);
    endfunction

    function automatic bit fwd(input logic [3:0] n);
        return BYP && bus.wb_rd_write_en && n == bus.wb_rd_num && int'(n) < NREG;
    endfunction

    function automatic logic [31:0] e_data(input logic [3:0] n);
        if (int'(n) >= NREG) return 32'h0;
        if (fwd(n)) return bus.wb_rd_in;
        return m_gpr[n];
    endfunction

    function automatic logic e_busy(input logic [3:0] n);
        if (int'(n) >= NREG) return 1'b0;
        if (fwd(n)) return bus.exe_lock_en && bus.exe_lock_num == n;
        return m_busy[n];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " pc"}, bus.if_pc_out, BYP && bus.wb_pc_write_en ? bus.wb_pc_in : m_pc);
        chk({tag, " cpsr"}, bus.exe_cpsr_out, BYP && bus.wb_cpsr_write_en ? merge(m_cpsr, bus.wb_cpsr_in) : m_cpsr);
        chk({tag, " rd"}, bus.exe_rd_data_out, e_data(bus.exe_rd_num));
        chk({tag, " rs"}, bus.exe_rs_data_out, e_data(bus.exe_rs_num));
        chk({tag, " rt"}, bus.exe_rt_data_out, e_data(bus.exe_rt_num));
        chk({tag, " rd_busy"}, 32'(bus.exe_rd_busy), 32'(e_busy(bus.exe_rd_num)));
        chk({tag, " rs_busy"}, 32'(bus.exe_rs_busy), 32'(e_busy(bus.exe_rs_num)));
        chk({tag, " rt_busy"}, 32'(bus.exe_rt_busy), 32'(e_busy(bus.exe_rt_num)));
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, " pc"}, bus.if_pc_out, PCR);
        chk({tag, " cpsr"}, bus.exe_cpsr_out, 32'h0);
        chk({tag, " rd"}, bus.exe_rd_data_out, 32'h0);
        chk({tag, " rs"}, bus.exe_rs_data_out, 32'h0);
        chk({tag, " rt"}, bus.exe_rt_data_out, 32'h0);
        chk({tag, " busy"}, {29'h0, bus.exe_rd_busy, bus.exe_rs_busy, bus.exe_rt_busy}, 32'h0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_gpr[i] = 32'h0;
            m_busy[i] = 1'b0;
        end
        m_pc = PCR;
        m_cpsr = 32'h0;
    endtask

    task automatic model_update();
        if (bus.wb_rd_write_en && int'(bus.wb_rd_num) < NREG) begin
            m_gpr[bus.wb_rd_num] = bus.wb_rd_in;
            m_busy[bus.wb_rd_num] = 1'b0;
        end
        if (bus.exe_lock_en && int'(bus.exe_lock_num) < NREG) m_busy[bus.exe_lock_num] = 1'b1;
        if (bus.wb_pc_write_en) m_pc = bus.wb_pc_in;
        else if (bus.if_pc_we) m_pc = bus.if_pc_in;
        if (bus.wb_cpsr_write_en) m_cpsr = merge(m_cpsr, bus.wb_cpsr_in);
    endtask

    task automatic idle();
        bus.if_pc_we = 1'b0;        bus.if_pc_in = 32'h0;
        bus.exe_rd_num = 4'd0;      bus.exe_rs_num = 4'd0;      bus.exe_rt_num = 4'd0;
        bus.exe_lock_en = 1'b0;     bus.exe_lock_num = 4'd0;
        bus.wb_rd_num = 4'd0;       bus.wb_rd_write_en = 1'b0;  bus.wb_rd_in = 32'h0;
        bus.wb_pc_write_en = 1'b0;  bus.wb_pc_in = 32'h0;
        bus.wb_cpsr_write_en = 1'b0; bus.wb_cpsr_in = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic add(input logic [31:0] pcwe, pcin, wpce, wpc, wr, wn, wd, cw, cd, lk, ln, rs,
                       input logic [31:0] e_rs, e_rsb, e_pc, e_cpsr);
        tbl.push_back('{pcwe, pcin, wpce, wpc, wr, wn, wd, cw, cd, lk, ln, rs, e_rs, e_rsb, e_pc, e_cpsr});
    endtask

    initial begin
        // Expected outputs are sampled before the clock edge that commits each vector.
        add(0, 0, 0, 0,      1, 5, 32'hDEADBEEF, 0, 0,   0, 0, 5,   BYP ? 32'hDEADBEEF : 0, 0, PCR, 0);
        add(0, 0, 0, 0,      0, 0, 0, 0, 0,              0, 0, 5,   32'hDEADBEEF, 0, PCR, 0);
        add(1, 4, 1, 32'h80, 0, 0, 0, 0, 0,              0, 0, 5,   32'hDEADBEEF, 0, BYP ? 32'h80 : PCR, 0);
        add(0, 0, 0, 0,      0, 0, 0, 0, 0,              0, 0, 5,   32'hDEADBEEF, 0, 32'h80, 0);
        add(0, 0, 0, 0,      0, 0, 0, 0, 0,              0, 0, 5,   32'hDEADBEEF, 0, 32'h80, 0);
        add(0, 0, 0, 0,      0, 0, 0, 1, 32'hFFFFFFFF,   0, 0, 5,   32'hDEADBEEF, 0, 32'h80, BYP ? MASK : 0);
        add(0, 0, 0, 0,      0, 0, 0, 0, 0,              1, 3, 3,   0, 0, 32'h80, MASK);
        add(0, 0, 0, 0,      1, 3, 32'h33, 0, 0,         1, 3, 3,   BYP ? 32'h33 : 0, 1, 32'h80, MASK);
        add(0, 0, 0, 0,      1, 3, 32'h44, 0, 0,         0, 0, 3,   BYP ? 32'h44 : 32'h33, BYP ? 0 : 1, 32'h80, MASK);
        add(0, 0, 0, 0,      0, 0, 0, 0, 0,              0, 0, 3,   32'h44, 0, 32'h80, MASK);
        add(0, 0, 0, 0,      1, 14, 32'h55, 0, 0,        1, 14, 14, 0, 0, 32'h80, MASK);
        add(0, 0, 0, 0,      0, 0, 0, 0, 0,              0, 0, 14,  0, 0, 32'h80, MASK);
        add(0, 0, 0, 0,      0, 0, 0, 0, 0,              0, 0, 5,   32'hDEADBEEF, 0, 32'h80, MASK);
        add(0, 0, 0, 0,      0, 0, 0, 1, 32'h0,          0, 0, 5,   32'hDEADBEEF, 0, 32'h80, BYP ? 0 : MASK);
        add(0, 0, 0, 0,      0, 0, 0, 0, 0,              0, 0, 5,   32'hDEADBEEF, 0, 32'h80, 0);

        idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outs("por");
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            bus.if_pc_we = tbl[i].pcwe[0];        bus.if_pc_in = tbl[i].pcin;
            bus.wb_pc_write_en = tbl[i].wpce[0];  bus.wb_pc_in = tbl[i].wpc;
            bus.wb_rd_write_en = tbl[i].wr[0];    bus.wb_rd_num = tbl[i].wn[3:0];  bus.wb_rd_in = tbl[i].wd;
            bus.wb_cpsr_write_en = tbl[i].cw[0];  bus.wb_cpsr_in = tbl[i].cd;
            bus.exe_lock_en = tbl[i].lk[0];       bus.exe_lock_num = tbl[i].ln[3:0];
            bus.exe_rs_num = tbl[i].rs[3:0];
            #1;
            chk($sformatf("vec%0d rs_data", i), bus.exe_rs_data_out, tbl[i].e_rs);
            chk($sformatf("vec%0d rs_busy", i), 32'(bus.exe_rs_busy), tbl[i].e_rsb);
            chk($sformatf("vec%0d pc", i), bus.if_pc_out, tbl[i].e_pc);
            chk($sformatf("vec%0d cpsr", i), bus.exe_cpsr_out, tbl[i].e_cpsr);
            tick();
        end

        for (int c = 0; c < 400; c++) begin
            bus.if_pc_we = $urandom_range(0, 1) == 0;         bus.if_pc_in = $urandom;
            bus.wb_pc_write_en = $urandom_range(0, 3) == 0;   bus.wb_pc_in = $urandom;
            bus.wb_rd_write_en = $urandom_range(0, 1) == 0;   bus.wb_rd_num = 4'($urandom_range(0, 15));
            bus.wb_rd_in = $urandom;
            bus.wb_cpsr_write_en = $urandom_range(0, 3) == 0; bus.wb_cpsr_in = $urandom;
            bus.exe_lock_en = $urandom_range(0, 2) == 0;      bus.exe_lock_num = 4'($urandom_range(0, 15));
            bus.exe_rd_num = 4'($urandom_range(0, 15));
            bus.exe_rs_num = $urandom_range(0, 3) == 0 ? bus.wb_rd_num : 4'($urandom_range(0, 15));
            bus.exe_rt_num = $urandom_range(0, 3) == 0 ? bus.exe_lock_num : 4'($urandom_range(0, 15));
            #1;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        // Asynchronous reset away from a clock edge, with every write/lock enable active.
        bus.wb_rd_write_en = 1'b1; bus.wb_rd_num = 4'd2; bus.wb_rd_in = 32'hA5A5A5A5;
        bus.wb_pc_write_en = 1'b1; bus.wb_pc_in = 32'h1234;
        bus.wb_cpsr_write_en = 1'b1; bus.wb_cpsr_in = 32'hFFFFFFFF;
        bus.exe_lock_en = 1'b1; bus.exe_lock_num = 4'd1;
        bus.exe_rd_num = 4'd1; bus.exe_rs_num = 4'd2; bus.exe_rt_num = 4'd5;
        #2 reset = 1'b0;
        #1;
        check_reset_outs("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outs("rst_hold");
        reset = 1'b1;
        idle();
        bus.exe_rd_num = 4'd1; bus.exe_rs_num = 4'd2; bus.exe_rt_num = 4'd5;
        #1;
        check_model("post_rst");
        tick();
        bus.wb_rd_write_en = 1'b1; bus.wb_rd_num = 4'd2; bus.wb_rd_in = 32'h0BADF00D;
        bus.if_pc_we = 1'b1; bus.if_pc_in = 32'h104;
        #1;
        check_model("post_rst_wr");
        tick();
        idle();
        bus.exe_rs_num = 4'd2;
        #1;
        check_model("post_rst_rd");
        chk("post_rst_r2", bus.exe_rs_data_out, 32'h0BADF00D);
        chk("post_rst_pc", bus.if_pc_out, 32'h104);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
